// File: rtl/yin_pkg.sv
// Shared YIN definitions: sweep FSM states, default lag range and accumulator sizing.
package yin_pkg;

  localparam int unsigned YIN_TAU_MIN = 1;
  localparam int unsigned YIN_TAU_MAX = 40;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    FLUSH,
    EMIT,
    FIN
  } state_t;

  // N squared differences of DATA_WIDTH-bit samples fit in 2*DATA_WIDTH + log2(N) bits.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned window_size_bits);
    return 2 * data_width + window_size_bits;
  endfunction

endpackage

// File: rtl/yin_diff_sweep_sq_diff_acc.sv
// Squared-difference accumulator: holds x[j], subtracts x[j+tau], squares and sums.
module sq_diff_acc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  load_a,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [DATA_WIDTH-1:0]          a_reg;
  logic signed [DATA_WIDTH:0]     diff;
  logic signed [2*DATA_WIDTH+1:0] sq;

  always_comb begin
    diff = $signed({1'b0, a_reg}) - $signed({1'b0, din});
    sq   = diff * diff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      acc   <= '0;
    end else begin
      if (load_a) a_reg <= din;
      if (clr)
        acc <= '0;
      else if (acc_en)
        acc <= acc + ACC_WIDTH'($unsigned(sq));
    end
  end

endmodule

// File: rtl/yin_diff_sweep.sv
// YIN difference-function sweep: reads the window from sample RAM for each lag,
// streams d(tau), tracks the minimum and optionally stops below a threshold.
module yin_diff_sweep
  import yin_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned WINDOW_SIZE_BITS = 8,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned TAU_BITS         = 6,
  parameter int unsigned TAU_MIN          = YIN_TAU_MIN,
  parameter int unsigned TAU_MAX          = YIN_TAU_MAX,
  parameter int unsigned ACC_WIDTH        = acc_width(DATA_WIDTH, WINDOW_SIZE_BITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  early_stop,
  input  logic [ACC_WIDTH-1:0]  threshold,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  res_valid,
  output logic [TAU_BITS-1:0]   res_tau,
  output logic [ACC_WIDTH-1:0]  res_diff,
  output logic                  done,
  output logic [TAU_BITS-1:0]   best_tau,
  output logic [ACC_WIDTH-1:0]  best_diff,
  output logic                  hit
);

  localparam logic [TAU_BITS-1:0]         TAU_LO = TAU_BITS'(TAU_MIN);
  localparam logic [TAU_BITS-1:0]         TAU_HI = TAU_BITS'(TAU_MAX);
  localparam logic [WINDOW_SIZE_BITS-1:0] J_LAST = '1;

  state_t                      state, state_nxt;
  logic [WINDOW_SIZE_BITS-1:0] j, j_nxt;
  logic [TAU_BITS-1:0]         tau, tau_nxt;
  logic [ADDR_WIDTH-1:0]       base_q, addr_nxt;
  logic                        es_q;
  logic [ACC_WIDTH-1:0]        thr_q;
  logic [ACC_WIDTH-1:0]        acc;
  logic                        acc_clr, acc_en, a_load;
  logic                        accept, stop_hit;
  logic [TAU_BITS-1:0]         res_tau_q;
  logic [ACC_WIDTH-1:0]        res_diff_q;

  sq_diff_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .load_a  (a_load),
    .acc_en  (acc_en),
    .din     (mem_data),
    .acc     (acc)
  );

  // mem_addr is registered, so the address for the next state is computed here.
  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    tau_nxt   = tau;
    addr_nxt  = mem_addr;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    a_load    = 1'b0;
    accept    = 1'b0;
    stop_hit  = es_q && (acc < thr_q);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          acc_clr   = 1'b1;
          j_nxt     = '0;
          tau_nxt   = TAU_LO;
          addr_nxt  = base_addr;
          state_nxt = RD_A;
        end
      end
      RD_A: begin
        acc_en    = (j != '0);
        addr_nxt  = base_q + ADDR_WIDTH'(j) + ADDR_WIDTH'(tau);
        state_nxt = RD_B;
      end
      RD_B: begin
        a_load = 1'b1;
        if (j == J_LAST) begin
          state_nxt = FLUSH;
        end else begin
          j_nxt     = j + 1'b1;
          addr_nxt  = base_q + ADDR_WIDTH'(j) + ADDR_WIDTH'(1);
          state_nxt = RD_A;
        end
      end
      FLUSH: begin
        acc_en    = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        if (stop_hit || tau == TAU_HI) begin
          state_nxt = FIN;
        end else begin
          tau_nxt   = tau + 1'b1;
          j_nxt     = '0;
          acc_clr   = 1'b1;
          addr_nxt  = base_q;
          state_nxt = RD_A;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      j          <= '0;
      tau        <= '0;
      mem_addr   <= '0;
      base_q     <= '0;
      es_q       <= 1'b0;
      thr_q      <= '0;
      best_tau   <= '0;
      best_diff  <= '0;
      hit        <= 1'b0;
      res_tau_q  <= '0;
      res_diff_q <= '0;
    end else begin
      state    <= state_nxt;
      j        <= j_nxt;
      tau      <= tau_nxt;
      mem_addr <= addr_nxt;
      if (accept) begin
        base_q    <= base_addr;
        es_q      <= early_stop;
        thr_q     <= threshold;
        best_tau  <= TAU_LO;
        best_diff <= '1;
        hit       <= 1'b0;
      end
      if (state == EMIT) begin
        res_tau_q  <= tau;
        res_diff_q <= acc;
        if (acc < best_diff) begin
          best_tau  <= tau;
          best_diff <= acc;
        end
        if (stop_hit) hit <= 1'b1;
      end
    end
  end

  assign mem_rd_en = (state == RD_A) || (state == RD_B);
  assign busy      = (state == RD_A) || (state == RD_B) || (state == FLUSH) || (state == EMIT);
  assign res_valid = (state == EMIT);
  assign done      = (state == FIN);
  assign res_tau   = res_valid ? tau : res_tau_q;
  assign res_diff  = res_valid ? acc : res_diff_q;

endmodule

// File: tb/tb_yin_diff_sweep.sv
// Scoreboard bench for yin_diff_sweep: expected results from a direct d(tau) model.
module tb_yin_diff_sweep;

  localparam int DW = 8, AW = 16, TB = 6, TMIN = 1, TMAX = 40, ACCW = 24;
  localparam int N = 256, PER = 2 * N + 2;
  localparam int SACCW = 20, STMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, start, early_stop;
  logic [AW-1:0]   base_addr;
  logic [ACCW-1:0] threshold;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_en;
  logic [DW-1:0]   mem_data;
  logic            busy, res_valid, done, hit;
  logic [TB-1:0]   res_tau, best_tau;
  logic [ACCW-1:0] res_diff, best_diff;

  logic [7:0] mem [0:65535];
  always @(posedge clk) mem_data <= mem[mem_addr];

  yin_diff_sweep #(
    .DATA_WIDTH(DW), .WINDOW_SIZE_BITS(8), .ADDR_WIDTH(AW), .TAU_BITS(TB),
    .TAU_MIN(TMIN), .TAU_MAX(TMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .early_stop(early_stop), .threshold(threshold), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_data(mem_data), .busy(busy), .res_valid(res_valid),
    .res_tau(res_tau), .res_diff(res_diff), .done(done), .best_tau(best_tau),
    .best_diff(best_diff), .hit(hit)
  );

  // Small-window instance on a ramp memory (x[i] = i mod 256), N = 16.
  logic             s_start, s_rd_en, s_busy, s_valid, s_done, s_hit;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_data;
  logic [TB-1:0]    s_tau, s_best_tau;
  logic [SACCW-1:0] s_diff, s_best_diff;
  always @(posedge clk) s_data <= 8'(s_addr);

  yin_diff_sweep #(
    .DATA_WIDTH(DW), .WINDOW_SIZE_BITS(4), .ADDR_WIDTH(AW), .TAU_BITS(TB),
    .TAU_MIN(1), .TAU_MAX(STMAX)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .base_addr(16'h0000),
    .early_stop(1'b0), .threshold('0), .mem_addr(s_addr),
    .mem_rd_en(s_rd_en), .mem_data(s_data), .busy(s_busy), .res_valid(s_valid),
    .res_tau(s_tau), .res_diff(s_diff), .done(s_done), .best_tau(s_best_tau),
    .best_diff(s_best_diff), .hit(s_hit)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int     exp_tau_q[$];
  longint exp_diff_q[$];
  int     exp_cyc_q[$];
  longint s_exp_q[$];
  bit     done_pend = 0, s_done_seen = 0, wrap_watch = 0, saw_wrap = 0;
  int     exp_done_cyc, exp_best_tau;
  longint exp_best_diff;
  bit     exp_hit;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint dref(input int base, input int tau);
    longint s = 0;
    for (int j = 0; j < N; j++) begin
      int a = int'(mem[(base + j) % 65536]);
      int b = int'(mem[(base + j + tau) % 65536]);
      s += longint'((a - b) * (a - b));
    end
    return s;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_tau"}, res_tau, 0);
    check({tag, "_res_diff"}, res_diff, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_best_tau"}, best_tau, 0);
    check({tag, "_best_diff"}, best_diff, 0);
    check({tag, "_hit"}, hit, 0);
  endtask

  task automatic launch(input int base, input bit es, input longint thr);
    longint best, d;
    int btau, k;
    bit h;
    @(negedge clk);
    best = (longint'(1) << ACCW) - 1;
    btau = TMIN; h = 0; k = 0;
    for (int tau = TMIN; tau <= TMAX; tau++) begin
      d = dref(base, tau);
      exp_tau_q.push_back(tau);
      exp_diff_q.push_back(d);
      exp_cyc_q.push_back(cyc + (k + 1) * PER);
      k++;
      if (d < best) begin best = d; btau = tau; end
      if (es && d < thr) begin h = 1; break; end
    end
    exp_done_cyc  = cyc + k * PER + 1;
    exp_best_tau  = btau;
    exp_best_diff = best;
    exp_hit       = h;
    done_pend     = 1;
    base_addr  = AW'(base);
    early_stop = es;
    threshold  = ACCW'(thr);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", limit);
      exp_tau_q.delete(); exp_diff_q.delete(); exp_cyc_q.delete();
      done_pend = 0;
    end
  endtask

  // Monitor: pops expected results whenever the DUT presents one.
  always @(negedge clk) begin
    int t, c;
    longint d;
    if (reset_n) begin
      if (res_valid) begin
        if (exp_tau_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got tau %0d, required no result", res_tau);
        end else begin
          t = exp_tau_q.pop_front();
          d = exp_diff_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("res_tau", res_tau, t);
          check("res_diff", res_diff, d);
          check("res_cycle", cyc, c);
        end
      end
      if (done) begin
        if (!done_pend) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          check("done_cycle", cyc, exp_done_cyc);
          check("best_tau", best_tau, exp_best_tau);
          check("best_diff", best_diff, exp_best_diff);
          check("hit", hit, exp_hit);
          check("done_busy", busy, 0);
          check("results_left", exp_tau_q.size(), 0);
          done_pend = 0;
        end
      end
      if (!mem_rd_en) check("addr_hold", mem_addr, prev_addr);
      if (s_valid) begin
        if (s_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL small_unexpected: got tau %0d, required no result", s_tau);
        end else begin
          d = s_exp_q.pop_front();
          check("small_res_diff", s_diff, d);
        end
      end
      if (s_done) begin
        check("small_best_tau", s_best_tau, 1);
        check("small_best_diff", s_best_diff, 16);
        check("small_hit", s_hit, 0);
        check("small_busy", s_busy, 0);
        check("small_left", s_exp_q.size(), 0);
        s_done_seen = 1;
      end
      if (wrap_watch && mem_rd_en && mem_addr < 16'h0010) saw_wrap = 1;
    end
    prev_addr = mem_addr;
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; s_start = 1'b0;
    early_stop = 1'b0; base_addr = '0; threshold = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h80;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Ramp: d(tau) = sum of tau^2 over 16 samples.
    for (int tau = 1; tau <= STMAX; tau++) s_exp_q.push_back(longint'(16 * tau * tau));
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;

    // Constant memory, with a start pulse during the sweep that must be ignored.
    launch(0, 1'b0, 0);
    repeat (1000) @(negedge clk);
    base_addr = 16'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(30000);
    start = 1'b1;  // in FIN: must be ignored
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("fin_start_ignored", busy, 0);

    // Sine with period 20 samples.
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'(int'(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * real'(i % 20) / 20.0)));
    launch(256, 1'b0, 0);
    wait_done(30000);
    check("sine_best_tau", best_tau, 20);
    launch(256, 1'b1, 2000);
    wait_done(30000);
    check("early_best_tau", best_tau, 20);
    check("early_hit", hit, 1);

    // Random data; reset in the middle of tau = 7.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    launch(16'h0040, 1'b0, 0);
    repeat (6 * PER + 100) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("abort");
    exp_tau_q.delete(); exp_diff_q.delete(); exp_cyc_q.delete();
    done_pend = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // Window wrapping through the top of memory.
    saw_wrap = 0; wrap_watch = 1;
    launch(16'hFFF0, 1'b0, 0);
    wait_done(30000);
    wrap_watch = 0;
    check("addr_wrap_seen", saw_wrap, 1);
    check("small_done_seen", s_done_seen, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
